sim_uart_tx_driver: RTL and testbench
=====================================

// Module: sim_uart_tx_driver
// PURPOSE
//  Bench-side UART transmitter that drives the DUT's i_uart1_rd line: the upstream stage of the
//  SoC UART1 receiver. Bytes are queued by a task/DPI layer through a valid/ready port and
//  serialized as 8-bit frames (start, LSB-first data, optional parity, 1/2 stop) at a
//  run-time bit period. Used in the ASIC/FPGA top-level bench alongside the UART RX monitor.
// PARAMETERS
//  p_fifo_log2   2     FIFO depth = 2**p_fifo_log2 bytes (range 1..6)
//  p_parity_en   0     1: append a parity bit after data
//  p_parity_odd  0     0: even parity, 1: odd parity (ignored when p_parity_en=0)
//  p_stop_bits   1     number of stop bits (1 or 2)
// PORTS
//  i_clk        in   1                 bench clock, all logic on rising edge
//  i_nrst       in   1                 asynchronous active-low reset
//  i_scaler     in   32                bit period in i_clk cycles; values <2 are treated as 2
//  i_we         in   1                 write strobe, byte accepted when i_we && o_wready
//  i_wdata      in   8                 byte to transmit
//  o_wready     out  1                 FIFO not full
//  o_td         out  1                 serial line to DUT i_uart1_rd, idle high
//  o_busy       out  1                 frame in progress or FIFO not empty
//  o_fifo_cnt   out  p_fifo_log2+1     bytes currently queued (excluding the byte on the wire)
// BEHAVIOUR
//  Reset (i_nrst=0, async): o_td=1, o_busy=0, o_wready=1, o_fifo_cnt=0, FSM=IDLE, FIFO emptied.
//   Reset asserted mid-frame aborts the frame; o_td returns to 1 asynchronously.
//  FIFO: circular, wr/rd pointers of p_fifo_log2+1 bits (MSB = wrap flag); full when pointers
//   differ only in the MSB. A write while full is dropped (no overwrite, no count change).
//   Simultaneous write and pop: both take effect, count unchanged; legal even when full because
//   o_wready is registered from the pre-pop state (the write is still dropped when full).
//  Bit timer: down-counter loaded with eff_scaler-1 at each bit start; bit ends when it reaches 0.
//   eff_scaler = max(i_scaler,2), latched at the IDLE->START transition. Changes of i_scaler
//   during a frame take effect at the next frame only.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE:   o_td=1; if FIFO non-empty, pop byte into shift reg, latch scaler, ->START next cycle.
//           Latency from first accepted write (empty FIFO) to o_td falling edge: 2 i_clk.
//   START:  o_td=0 for one bit period ->DATA, bit_idx=0.
//   DATA:   o_td=shift[0]; at bit end shift right, bit_idx++; after bit_idx 7 ->PARITY
//           (if p_parity_en) else ->STOP.
//   PARITY: o_td = ^byte ^ p_parity_odd for one bit period ->STOP.
//   STOP:   o_td=1 for p_stop_bits bit periods; then if FIFO non-empty pop and ->START directly
//           (no idle gap, back-to-back frames), else ->IDLE.
//  o_td is a registered output (no glitches). Frame length = (10+p_parity_en+p_stop_bits-1)*eff_scaler.
//  o_busy = (state!=IDLE) || (o_fifo_cnt!=0).
// STRUCTURE
//  sim_uart_pkg: typedef enum logic [2:0] uart_tx_state_t {IDLE,START,DATA,PARITY,STOP};
//   constant UART_MIN_SCALER=2; shared with the RX monitor.
//  Sub-module sim_uart_tx_fifo (parameter p_log2, 8-bit data, wr/rd/full/empty/count);
//   top holds the bit timer, bit index, shift register and FSM.
// TESTING
//  1. i_scaler=8, write 8'h55 -> o_td: 0,1,0,1,0,1,0,1,0,1 each 8 clk, then idle high;
//     falling edge 2 clk after write; o_busy deasserts after last stop bit.
//  2. i_scaler=4, write 4 bytes 8'h00,8'hFF,8'hA5,8'h3C in consecutive cycles (depth 4) ->
//     o_fifo_cnt peaks at 3, frames back-to-back with no idle cycle, RX monitor decodes same order.
//  3. Depth 4: write 6 bytes with FSM busy -> o_wready low after 4th queued, 5th/6th dropped,
//     only 5 bytes total on the wire (1 in flight + 4 queued).
//  4. p_parity_en=1, p_parity_odd=0, p_stop_bits=2, i_scaler=3, byte 8'h07 -> parity bit 1,
//     stop high for 6 clk; frame = 12 bits*3 = 36 clk.
//  5. i_scaler=0 -> bit period 2 clk; change i_scaler 8->16 mid-frame -> current frame stays 8,
//     next frame 16 clk/bit.
//  6. Pull i_nrst low during DATA bit 3 -> o_td=1 immediately, o_fifo_cnt=0, o_wready=1;
//     after release a new write yields a clean full frame.

Source files
------------

// File: rtl/sim_uart_pkg.sv
// rtl/sim_uart_pkg.sv - shared UART bench types and constants
package sim_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   // Shortest bit period the serializer supports, in bench clocks
   localparam logic [31:0] UART_MIN_SCALER = 32'd2;

   // Bit period actually used: requests below the minimum are clamped up
   function automatic logic [31:0] uart_eff_scaler(input logic [31:0] scaler);
      return (scaler < UART_MIN_SCALER) ? UART_MIN_SCALER : scaler;
   endfunction

endpackage

// File: rtl/sim_uart_tx_fifo.sv
// rtl/sim_uart_tx_fifo.sv - byte FIFO queueing bytes ahead of the UART serializer
module sim_uart_tx_fifo #(
   parameter int p_log2 = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic [7:0]        wdata,
   input  logic              rd,
   output logic [7:0]        rdata,
   output logic              full,
   output logic              empty,
   output logic [p_log2:0]   count
);

   localparam int              DEPTH   = 1 << p_log2;
   localparam logic [p_log2:0] PTR_ONE = {{p_log2{1'b0}}, 1'b1};

   logic [7:0]      mem [DEPTH];
   logic [p_log2:0] wr_ptr;
   logic [p_log2:0] rd_ptr;
   logic            do_wr;
   logic            do_rd;

   // Pointers carry an extra wrap bit: equal low bits with differing wrap bit means full
   assign full  = (wr_ptr[p_log2] != rd_ptr[p_log2]) &&
                  (wr_ptr[p_log2-1:0] == rd_ptr[p_log2-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign count = wr_ptr - rd_ptr;
   assign do_wr = wr && !full;
   assign do_rd = rd && !empty;
   assign rdata = mem[rd_ptr[p_log2-1:0]];

   // Storage array; a write while full is silently dropped
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr[p_log2-1:0]] <= wdata;
      end
   end

   // Pointer advance; write and pop in the same cycle both take effect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/sim_uart_tx_driver.sv
// rtl/sim_uart_tx_driver.sv - bench-side UART transmitter driving a serial receive line
module sim_uart_tx_driver
   import sim_uart_pkg::*;
#(
   parameter int p_fifo_log2  = 2,
   parameter int p_parity_en  = 0,
   parameter int p_parity_odd = 0,
   parameter int p_stop_bits  = 1
) (
   input  logic                   i_clk,
   input  logic                   i_nrst,
   input  logic [31:0]            i_scaler,
   input  logic                   i_we,
   input  logic [7:0]             i_wdata,
   output logic                   o_wready,
   output logic                   o_td,
   output logic                   o_busy,
   output logic [p_fifo_log2:0]   o_fifo_cnt
);

   localparam bit   PAR_EN    = (p_parity_en != 0);
   localparam logic PAR_ODD   = (p_parity_odd != 0) ? 1'b1 : 1'b0;
   localparam logic STOP_LAST = (p_stop_bits >= 2) ? 1'b1 : 1'b0;

   uart_tx_state_t state_q, state_d;
   logic [31:0]    timer_q, timer_d;
   logic [31:0]    scaler_q, scaler_d;
   logic [7:0]     shift_q, shift_d;
   logic [2:0]     bit_idx_q, bit_idx_d;
   logic           stop_cnt_q, stop_cnt_d;
   logic           par_q, par_d;
   logic           td_q, td_d;
   logic           load_frame;
   logic           pop;
   logic [7:0]     fifo_rdata;
   logic           fifo_full;
   logic           fifo_empty;
   logic [31:0]    eff_in;
   logic [31:0]    reload;
   logic           bit_end;

   sim_uart_tx_fifo #(
      .p_log2 (p_fifo_log2)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_nrst),
      .wr    (i_we),
      .wdata (i_wdata),
      .rd    (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (o_fifo_cnt)
   );

   assign eff_in   = uart_eff_scaler(i_scaler);
   assign reload   = scaler_q - 32'd1;
   assign bit_end  = (timer_q == 32'd0);
   assign o_td     = td_q;
   assign o_wready = !fifo_full;
   assign o_busy   = (state_q != IDLE) || (o_fifo_cnt != '0);

   // Next-state, bit timing and line level for the current state
   always_comb begin
      state_d    = state_q;
      timer_d    = bit_end ? timer_q : timer_q - 32'd1;
      scaler_d   = scaler_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = stop_cnt_q;
      par_d      = par_q;
      td_d       = 1'b1;
      load_frame = 1'b0;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               load_frame = 1'b1;
            end
         end
         START: begin
            td_d = 1'b0;
            if (bit_end) begin
               state_d   = DATA;
               bit_idx_d = 3'd0;
               timer_d   = reload;
            end
         end
         DATA: begin
            td_d = shift_q[0];
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               timer_d = reload;
               if (bit_idx_q == 3'd7) begin
                  state_d    = PAR_EN ? PARITY : STOP;
                  stop_cnt_d = 1'b0;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            td_d = par_q;
            if (bit_end) begin
               state_d    = STOP;
               stop_cnt_d = 1'b0;
               timer_d    = reload;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop_cnt_q == STOP_LAST) begin
                  if (!fifo_empty) begin
                     load_frame = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  stop_cnt_d = 1'b1;
                  timer_d    = reload;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Frame start: pop the byte and freeze the bit period for the whole frame
      if (load_frame) begin
         pop      = 1'b1;
         shift_d  = fifo_rdata;
         par_d    = (^fifo_rdata) ^ PAR_ODD;
         scaler_d = eff_in;
         timer_d  = eff_in - 32'd1;
         state_d  = START;
      end
   end

   // State and datapath registers; reset forces the line idle high at once
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q    <= IDLE;
         timer_q    <= 32'd0;
         scaler_q   <= UART_MIN_SCALER;
         shift_q    <= 8'd0;
         bit_idx_q  <= 3'd0;
         stop_cnt_q <= 1'b0;
         par_q      <= 1'b0;
         td_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         scaler_q   <= scaler_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         stop_cnt_q <= stop_cnt_d;
         par_q      <= par_d;
         td_q       <= td_d;
      end
   end

endmodule

// File: tb/tb_sim_uart_tx_driver.sv
// tb/tb_sim_uart_tx_driver.sv - self-checking bench for the UART transmit driver
module tb_sim_uart_tx_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic        sel;
   logic [7:0]  wdata;
   logic [31:0] scaler;
   logic        we_a, we_b;
   logic        wready_a, td_a, busy_a;
   logic        wready_b, td_b, busy_b;
   logic [2:0]  cnt_a, cnt_b;
   logic        line, busy, wready;
   logic [2:0]  cnt;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  wbuf [8];
   int          wn;
   int          peak;

   typedef struct {
      logic [31:0] scaler;
      logic [7:0]  data;
      int          eff;
      logic [7:0]  exp_byte;
   } vec_t;
   vec_t vecs [6];

   always #5 clk = ~clk;

   assign we_a   = we & ~sel;
   assign we_b   = we & sel;
   assign line   = sel ? td_b : td_a;
   assign busy   = sel ? busy_b : busy_a;
   assign wready = sel ? wready_b : wready_a;
   assign cnt    = sel ? cnt_b : cnt_a;

   sim_uart_tx_driver #(
      .p_fifo_log2 (2), .p_parity_en (0), .p_parity_odd (0), .p_stop_bits (1)
   ) dut_a (
      .i_clk (clk), .i_nrst (rst_n), .i_scaler (scaler), .i_we (we_a), .i_wdata (wdata),
      .o_wready (wready_a), .o_td (td_a), .o_busy (busy_a), .o_fifo_cnt (cnt_a)
   );

   sim_uart_tx_driver #(
      .p_fifo_log2 (2), .p_parity_en (1), .p_parity_odd (0), .p_stop_bits (2)
   ) dut_b (
      .i_clk (clk), .i_nrst (rst_n), .i_scaler (scaler), .i_we (we_b), .i_wdata (wdata),
      .o_wready (wready_b), .o_td (td_b), .o_busy (busy_b), .o_fifo_cnt (cnt_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference line level for bit slot idx of a frame carrying byte b
   function automatic logic model_bit(input logic [7:0] b, input int pe, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (pe != 0 && idx == 9) return ^b;
      return 1'b1;
   endfunction

   function automatic int model_eff(input logic [31:0] s);
      return (s < 32'd2) ? 2 : int'(s);
   endfunction

   // Write wbuf[0..wn-1] on consecutive cycles, tracking the peak queue depth
   task automatic burst();
      peak = 0;
      for (int i = 0; i < wn; i++) begin
         @(negedge clk);
         if (int'(cnt) > peak) peak = int'(cnt);
         we    = 1'b1;
         wdata = wbuf[i];
      end
      @(negedge clk);
      if (int'(cnt) > peak) peak = int'(cnt);
      we = 1'b0;
   endtask

   // Wait for a start bit, then compare every cycle of the frame with the model
   task automatic recv(input logic [7:0] exp, input int eff, output int gap, output logic [7:0] got);
      int nb, bad, first, pe;
      pe    = sel ? 1 : 0;
      nb    = sel ? 12 : 10;
      gap   = 0;
      got   = 8'd0;
      bad   = 0;
      first = -1;
      @(negedge clk);
      while (line !== 1'b0 && gap < 3000) begin
         gap++;
         @(negedge clk);
      end
      if (line !== 1'b0) begin
         chk("start_bit_timeout", 32'd1, 32'd0);
         gap = -1;
         return;
      end
      for (int c = 0; c < nb * eff; c++) begin
         if (c > 0) @(negedge clk);
         if (line !== model_bit(exp, pe, c / eff)) begin
            if (bad == 0) first = c;
            bad++;
         end
         if ((c % eff) == (eff / 2) && (c / eff) >= 1 && (c / eff) <= 8) got[c/eff-1] = line;
      end
      chk($sformatf("frame_%02h_bad_cycles_first_at_%0d", exp, first), bad, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int         gap, w, extra, eff;
      logic [7:0] got;
      rst_n  = 1'b0;
      we     = 1'b0;
      wdata  = 8'd0;
      sel    = 1'b0;
      scaler = 32'd8;

      vecs[0] = '{32'd8, 8'h55, 8, 8'h55};
      vecs[1] = '{32'd0, 8'hA3, 2, 8'hA3};
      vecs[2] = '{32'd1, 8'h01, 2, 8'h01};
      vecs[3] = '{32'd2, 8'h80, 2, 8'h80};
      vecs[4] = '{32'd5, 8'hE7, 5, 8'hE7};
      vecs[5] = '{32'd3, 8'h3C, 3, 8'h3C};

      repeat (3) @(negedge clk);
      chk("reset_td_a", td_a, 1);
      chk("reset_busy_a", busy_a, 0);
      chk("reset_wready_a", wready_a, 1);
      chk("reset_cnt_a", cnt_a, 0);
      chk("reset_td_b", td_b, 1);
      chk("reset_busy_b", busy_b, 0);
      rst_n = 1'b1;

      // Single frames over a range of bit periods, including clamped ones
      for (int v = 0; v < 6; v++) begin
         scaler  = vecs[v].scaler;
         wbuf[0] = vecs[v].data;
         wn      = 1;
         burst();
         recv(vecs[v].data, vecs[v].eff, gap, got);
         chk($sformatf("vec%0d_latency_gap", v), gap, 1);
         chk($sformatf("vec%0d_byte", v), got, vecs[v].exp_byte);
         @(negedge clk);
         chk($sformatf("vec%0d_busy_after", v), busy, 0);
         chk($sformatf("vec%0d_idle_td", v), line, 1);
      end

      // Four bytes back to back
      scaler = 32'd4;
      wbuf[0] = 8'h00; wbuf[1] = 8'hFF; wbuf[2] = 8'hA5; wbuf[3] = 8'h3C;
      wn = 4;
      fork
         burst();
         begin
            for (int i = 0; i < 4; i++) begin
               recv(wbuf[i], 4, gap, got);
               if (i > 0) chk($sformatf("b2b_gap_%0d", i), gap, 0);
               chk($sformatf("b2b_byte_%0d", i), got, wbuf[i]);
            end
         end
      join
      chk("b2b_peak_cnt", peak, 3);
      @(negedge clk);
      chk("b2b_busy_after", busy, 0);

      // Overflow: seven writes, last two dropped
      for (int i = 0; i < 7; i++) wbuf[i] = 8'h10 + 8'(i);
      wn = 7;
      fork
         begin
            burst();
            chk("full_wready", wready, 0);
            chk("full_cnt", cnt, 4);
         end
         begin
            for (int i = 0; i < 5; i++) begin
               recv(wbuf[i], 4, gap, got);
               if (i > 0) chk($sformatf("ovf_gap_%0d", i), gap, 0);
            end
         end
      join
      extra = 0;
      repeat (80) begin
         @(negedge clk);
         if (line === 1'b0) extra = 1;
      end
      chk("ovf_no_extra_frame", extra, 0);
      chk("ovf_busy_after", busy, 0);

      // Parity plus two stop bits on the second instance
      sel     = 1'b1;
      scaler  = 32'd3;
      wbuf[0] = 8'h07;
      wn      = 1;
      burst();
      recv(8'h07, 3, gap, got);
      chk("par_latency_gap", gap, 1);
      chk("par_byte", got, 8'h07);
      @(negedge clk);
      chk("par_idle_td", line, 1);
      chk("par_busy_after", busy, 0);
      sel = 1'b0;

      // Bit period change mid-frame applies to the following frame only
      scaler  = 32'd8;
      wbuf[0] = 8'h5A;
      wbuf[1] = 8'hC3;
      wn      = 2;
      fork
         burst();
         begin
            recv(8'h5A, 8, gap, got);
            recv(8'hC3, 16, gap, got);
            chk("scaler_change_gap", gap, 0);
         end
         begin
            repeat (30) @(negedge clk);
            scaler = 32'd16;
         end
      join
      @(negedge clk);

      // Reset during data bit 3
      scaler  = 32'd8;
      wbuf[0] = 8'h00;
      wbuf[1] = 8'h00;
      wn      = 2;
      burst();
      w = 0;
      while (line !== 1'b0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("rst_start_seen", line, 0);
      repeat (35) @(negedge clk);
      chk("rst_pre_td", line, 0);
      chk("rst_pre_busy", busy, 1);
      chk("rst_pre_cnt", cnt, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_td", line, 1);
      chk("rst_async_cnt", cnt, 0);
      chk("rst_async_wready", wready, 1);
      chk("rst_async_busy", busy, 0);
      @(negedge clk);
      rst_n   = 1'b1;
      wbuf[0] = 8'hC3;
      wn      = 1;
      burst();
      recv(8'hC3, 8, gap, got);
      chk("rst_after_gap", gap, 1);
      chk("rst_after_byte", got, 8'hC3);
      @(negedge clk);

      // Random bursts against the frame model
      for (int r = 0; r < 12; r++) begin
         scaler = $urandom_range(0, 6);
         eff    = model_eff(scaler);
         wn     = $urandom_range(1, 4);
         for (int i = 0; i < wn; i++) wbuf[i] = 8'($urandom);
         fork
            burst();
            begin
               for (int i = 0; i < wn; i++) begin
                  recv(wbuf[i], eff, gap, got);
                  if (i > 0) chk($sformatf("rnd%0d_gap_%0d", r, i), gap, 0);
               end
            end
         join
         @(negedge clk);
         chk($sformatf("rnd%0d_busy_after", r), busy, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
